ps2_keyboard_decoder: RTL
=========================

Name: ps2_keyboard_decoder

Overview:
- Receives raw PS/2 keyboard frames on the ps2_clk/ps2_data lines.
- Decodes scan-code set 2 make codes into uppercase ASCII.
- Drives the ASCII byte plus a one-cycle data-ready strobe into the music controller's keyboard_input / kybrd_data_ready inputs.
- Sits between the board PS/2 pins and every keyboard consumer in the 50 MHz domain.

Parameters:
- FILTER_LEN, 4: consecutive equal samples required before synchronized ps2_clk is accepted as a new level (glitch filter).
- TIMEOUT_CYCLES, 50000: clk cycles (1 ms at 50 MHz) without a filtered ps2_clk falling edge before an in-progress frame is aborted.

Ports:
- clk  input  1  50 MHz system clock
- reset  input  1  synchronous, active-high reset
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous
- ps2_data  input  1  raw PS/2 data pin, asynchronous
- ascii_out  output  8  last decoded ASCII key; held until the next valid make code
- kybrd_data_ready  output  1  one-cycle pulse when ascii_out is loaded
- frame_error  output  1  one-cycle pulse on parity, start or stop error, or on timeout abort

Behaviour:
- Reset values: ascii_out=8'h00, kybrd_data_ready=0, frame_error=0, FSM=IDLE, break/extend flags cleared, bit counter cleared.
- Synchronous reset has priority over everything, including in mid-frame. No partial frame survives reset.
- Input sync: ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - ps2_clk then passes the FILTER_LEN glitch filter.
  - A "fall" event is one cycle where filtered ps2_clk goes 1->0.
  - ps2_data is sampled in that same cycle.
- Frame format: start bit (0), 8 data bits LSB first, odd parity, stop bit (1). 11 falls in total.
- FSM states:
  - IDLE: on a fall with data=0, go to RECV with bit_cnt=1. A fall with data=1 is ignored.
  - RECV: shift one bit on each fall. At the 11th fall go to CHECK.
  - CHECK: one cycle. Validate parity and stop bit, then return to IDLE.
- Timeout: in RECV, a counter resets on each fall. On reaching TIMEOUT_CYCLES, go to IDLE, pulse frame_error, and drop the frame. The counter is idle in IDLE.
- Byte handling in CHECK, valid frame only:
  - 8'hF0: set break flag, no output.
  - 8'hE0: set extend flag, no output.
  - Any other byte with break or extend flag set: clear both flags, no output. Key releases and extended keys are never reported.
  - Otherwise: look up the byte in the ASCII table.
    - Mapped: ascii_out<=code and kybrd_data_ready<=1 for exactly one cycle, the cycle after CHECK.
    - Unmapped: no output, ascii_out unchanged.
- Invalid frame in CHECK (bad parity or stop=0): pulse frame_error, leave the flags untouched, no output.
- Latency: kybrd_data_ready rises 2 clk cycles after the cycle that detects the 11th fall.
- Typematic repeats (same make code again) produce a new pulse every time.
- ASCII table, scan set 2:
  - A-Z map to 8'h41-8'h5A (e.g. B=32, D=23, E=24, F=2B, R=2D).
  - 0-9 map to 8'h30-8'h39.
  - Space (29) maps to 8'h20.
  - Everything else is unmapped.
- kybrd_data_ready and frame_error never assert in the same cycle.

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
- Defined: the parity check is performed as above.
- Undefined: the parity bit is shifted in but ignored. Only a stop bit of 0 or a timeout causes frame_error, and bad-parity frames are decoded normally.

Decomposition:
- Package ps2_pkg holds:
  - the FSM state enum (IDLE, RECV, CHECK)
  - constants BREAK_CODE=8'hF0 and EXTEND_CODE=8'hE0
  - the frame length constant 11
  - function scan_to_ascii(input [7:0]) returning {valid, ascii[7:0]}
- One sub-module, ps2_line_sync: 2-flop synchronizers, glitch filter and fall detect. Outputs ps2_fall and ps2_data_s.

Test Plan:
- Frame 0x32 with correct parity -> ascii_out=8'h42 and kybrd_data_ready high for 1 cycle, 2 cycles after the last fall.
- Frames F0 then 32 after ascii_out=8'h42 -> no kybrd_data_ready, ascii_out stays 8'h42, flags cleared afterwards.
- Frame 0x2D with an even-parity bit -> frame_error pulses once, no data_ready, ascii_out unchanged. Same frame without PS2_PARITY_CHECK_EN -> ascii_out=8'h52.
- 5 bits of a frame, then ps2_clk held high for 50000 cycles -> frame_error pulse, FSM in IDLE. A following valid 0x24 frame -> ascii_out=8'h45.
- E0 then 75 -> no output. A following 0x23 -> ascii_out=8'h44 with a pulse.
- Reset asserted after bit 6 of frame 0x2B, then a full 0x2B frame -> outputs at reset values until the new frame, then ascii_out=8'h46 with a single pulse.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM states, framing constants and the scan-set-2 to ASCII table
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXTEND_CODE = 8'hE0;
  localparam int FRAME_LEN = 11;
  // returns {valid, ascii}; valid=0 for anything outside A-Z, 0-9 and space
  function automatic logic [8:0] scan_to_ascii(input logic [7:0] code);
    logic [7:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = "A"; 8'h32: a = "B"; 8'h21: a = "C"; 8'h23: a = "D";
      8'h24: a = "E"; 8'h2B: a = "F"; 8'h34: a = "G"; 8'h33: a = "H";
      8'h43: a = "I"; 8'h3B: a = "J"; 8'h42: a = "K"; 8'h4B: a = "L";
      8'h3A: a = "M"; 8'h31: a = "N"; 8'h44: a = "O"; 8'h4D: a = "P";
      8'h15: a = "Q"; 8'h2D: a = "R"; 8'h1B: a = "S"; 8'h2C: a = "T";
      8'h3C: a = "U"; 8'h2A: a = "V"; 8'h1D: a = "W"; 8'h22: a = "X";
      8'h35: a = "Y"; 8'h1A: a = "Z";
      8'h45: a = "0"; 8'h16: a = "1"; 8'h1E: a = "2"; 8'h26: a = "3";
      8'h25: a = "4"; 8'h2E: a = "5"; 8'h36: a = "6"; 8'h3D: a = "7";
      8'h3E: a = "8"; 8'h46: a = "9";
      8'h29: a = " ";
      default: a = 8'h00;
    endcase
    return {a != 8'h00, a};
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronizers, ps2_clk glitch filter and filtered falling-edge detect
module ps2_line_sync #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic ps2_fall,
  output logic ps2_data_s
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] clk_sync, data_sync;
  logic filt;
  logic [CW-1:0] cnt;
  // a new level is accepted only after FILTER_LEN consecutive samples disagree with the current one
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= 2'b11;
      data_sync <= 2'b11;
      filt <= 1'b1;
      cnt <= '0;
      ps2_fall <= 1'b0;
      ps2_data_s <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      ps2_data_s <= data_sync[1];
      ps2_fall <= 1'b0;
      if (clk_sync[1] == filt) cnt <= '0;
      else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= clk_sync[1];
        cnt <= '0;
        ps2_fall <= filt;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ps2_keyboard_decoder.sv
// ps2_keyboard_decoder: PS/2 frame receiver and make-code to ASCII decoder.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_keyboard_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ascii_out,
  output logic       kybrd_data_ready,
  output logic       frame_error
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic fall, data_s, brk, ext, frame_ok;
  state_t state;
  logic [3:0] bit_cnt;
  logic [9:0] shreg;
  logic [TW-1:0] tcnt;
  logic [8:0] map;
  ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_fall(fall), .ps2_data_s(data_s)
  );
  assign map = scan_to_ascii(shreg[7:0]);
`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = shreg[9] & ^shreg[8:0];
`else
  assign frame_ok = shreg[9];
`endif
  // shreg collects data[7:0], parity, stop; the start bit is consumed in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      tcnt <= '0;
      brk <= 1'b0;
      ext <= 1'b0;
      ascii_out <= 8'h00;
      kybrd_data_ready <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      kybrd_data_ready <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: if (fall && !data_s) begin
          state <= RECV;
          bit_cnt <= 4'd1;
          tcnt <= '0;
        end
        RECV: if (fall) begin
          shreg <= {data_s, shreg[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
          tcnt <= '0;
          if (bit_cnt == 4'(FRAME_LEN - 1)) state <= CHECK;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state <= IDLE;
          frame_error <= 1'b1;
        end else tcnt <= tcnt + 1'b1;
        CHECK: begin
          state <= IDLE;
          if (!frame_ok) frame_error <= 1'b1;
          else if (shreg[7:0] == BREAK_CODE) brk <= 1'b1;
          else if (shreg[7:0] == EXTEND_CODE) ext <= 1'b1;
          else if (brk || ext) begin
            brk <= 1'b0;
            ext <= 1'b0;
          end else if (map[8]) begin
            ascii_out <= map[7:0];
            kybrd_data_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
